// File: rtl/pc_sequencer.sv
// Next-PC sequencer: chooses between halt, execute redirects, stalls, BTB prediction and npc.
// Define BRANCH_PRED_EN to compile in the direct-mapped branch target buffer.
module pc_sequencer #(
   parameter int BTB_ENTRIES = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] curr_pc,
   input  logic [31:0] npc,
   output logic        en,
   output logic [31:0] new_pc,
   input  logic        ihit,
   input  logic        stall,
   input  logic        halt,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   input  logic        br_resolve,
   input  logic [31:0] br_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        pred_taken,
   output logic        halted
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PENDING = 2'd1,
      HALTED  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pend_q, pend_d;
   logic        btb_hit;
   logic [31:0] btb_tgt;
   logic [31:0] redir_al;
   logic [31:0] npc_al;
   logic        unused_ok;

   assign redir_al = {redir_pc[31:2], 2'b00};
   assign npc_al   = {npc[31:2], 2'b00};

`ifdef BRANCH_PRED_EN
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
   logic [29:0]            btb_tgt_q [BTB_ENTRIES];
   logic [1:0]             btb_ctr_q [BTB_ENTRIES];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;
   logic             wr_match;
   logic             wr_en;
   logic             wr_tgt_en;
   logic [1:0]       wr_ctr;

   assign rd_idx  = curr_pc[IDX_W+1:2];
   assign rd_tag  = curr_pc[31:IDX_W+2];
   assign wr_idx  = br_pc[IDX_W+1:2];
   assign wr_tag  = br_pc[31:IDX_W+2];

   // Lookup reads the stored arrays directly, so a same-cycle update is not yet visible.
   assign btb_hit = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag) && btb_ctr_q[rd_idx][1];
   assign btb_tgt = {btb_tgt_q[rd_idx], 2'b00};
   assign wr_match = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);

   always_comb begin
      btb_valid_d = btb_valid_q;
      wr_en       = 1'b0;
      wr_tgt_en   = 1'b0;
      wr_ctr      = btb_ctr_q[wr_idx];
      if (br_resolve) begin
         if (wr_match) begin
            wr_en = 1'b1;
            if (br_taken) begin
               wr_tgt_en = 1'b1;
               if (btb_ctr_q[wr_idx] != 2'b11) wr_ctr = btb_ctr_q[wr_idx] + 2'b01;
            end else if (btb_ctr_q[wr_idx] != 2'b00) begin
               wr_ctr = btb_ctr_q[wr_idx] - 2'b01;
            end
         end else if (br_taken) begin
            wr_en               = 1'b1;
            wr_tgt_en           = 1'b1;
            wr_ctr              = 2'b10;
            btb_valid_d[wr_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) btb_valid_q <= '0;
      else       btb_valid_q <= btb_valid_d;
   end

   // Payload needs no reset: every read is qualified by the valid bit.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         btb_ctr_q[wr_idx] <= wr_ctr;
         btb_tag_q[wr_idx] <= wr_tag;
         if (wr_tgt_en) btb_tgt_q[wr_idx] <= br_target[31:2];
      end
   end

   assign unused_ok = ^{curr_pc[1:0], br_pc[1:0], br_target[1:0], npc[1:0], redir_pc[1:0]};
`else
   assign btb_hit   = 1'b0;
   assign btb_tgt   = 32'd0;
   assign unused_ok = ^{curr_pc, br_resolve, br_pc, br_taken, br_target, npc[1:0], redir_pc[1:0]};
`endif

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      en         = 1'b0;
      new_pc     = 32'd0;
      pred_taken = 1'b0;
      if (halt || state_q == HALTED) begin
         state_d = HALTED;
         pend_d  = 32'd0;
      end else if (state_q == PENDING) begin
         if (ihit) begin
            en      = 1'b1;
            new_pc  = redir_valid ? redir_al : pend_q;
            state_d = RUN;
         end else if (redir_valid) begin
            pend_d = redir_al;
         end
      end else begin
         if (redir_valid) begin
            if (ihit) begin
               en     = 1'b1;
               new_pc = redir_al;
            end else begin
               pend_d  = redir_al;
               state_d = PENDING;
            end
         end else if (ihit && !stall) begin
            en         = 1'b1;
            new_pc     = btb_hit ? btb_tgt : npc_al;
            pred_taken = btb_hit;
         end
      end
      // Outputs are forced quiet for the whole reset assertion, not only after an edge.
      if (!nRST) begin
         en         = 1'b0;
         new_pc     = 32'd0;
         pred_taken = 1'b0;
      end
   end

   assign halted = nRST && (state_q == HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         pend_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a spec-level model is compared every cycle, plus
// literal directed sequences. Matches the DUT build whether or not BRANCH_PRED_EN is defined.
module tb_pc_sequencer;

   localparam int N  = 8;
   localparam int IW = 3;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] curr_pc, npc, redir_pc, br_pc, br_target;
   logic        ihit, stall, halt, redir_valid, br_resolve, br_taken;
   logic        en, pred_taken, halted;
   logic [31:0] new_pc;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.BTB_ENTRIES(N)) dut (
      .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc), .npc(npc), .en(en), .new_pc(new_pc),
      .ihit(ihit), .stall(stall), .halt(halt), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .br_resolve(br_resolve), .br_pc(br_pc), .br_taken(br_taken), .br_target(br_target),
      .pred_taken(pred_taken), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: halted flag, pending redirect, and a BTB held as plain arrays.
   bit          m_halted = 0, n_halted;
   bit          m_pend = 0, n_pend;
   logic [31:0] m_pend_pc = 0, n_pend_pc;
   bit          m_v [N], n_v [N];
   logic [31:0] m_tag [N], n_tag [N];
   logic [31:0] m_tgt [N], n_tgt [N];
   int          m_ctr [N], n_ctr [N];

   initial begin
      foreach (m_v[i]) begin
         m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
   end

   // Compare process: checks outputs at each negedge, commits model state at posedge.
   initial begin
      logic        e_en, e_pred, hit;
      logic [31:0] e_pc, ra;
      int          li, wi;
      logic [31:0] wt;
      forever begin
         @(negedge CLK);
         n_halted = m_halted; n_pend = m_pend; n_pend_pc = m_pend_pc;
         n_v = m_v; n_tag = m_tag; n_tgt = m_tgt; n_ctr = m_ctr;
         if (!nRST) begin
            chk("rst_en", 32'(en), 32'd0);
            chk("rst_new_pc", new_pc, 32'd0);
            chk("rst_pred", 32'(pred_taken), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            n_halted = 0; n_pend = 0; n_pend_pc = 0;
            foreach (n_v[i]) n_v[i] = 0;
         end else begin
            ra = redir_pc & 32'hFFFF_FFFC;
            e_en = 0; e_pred = 0; e_pc = 0; hit = 0;
`ifdef BRANCH_PRED_EN
            li  = int'((curr_pc >> 2) % N);
            hit = m_v[li] && (m_tag[li] == (curr_pc >> (IW + 2))) && (m_ctr[li] >= 2);
`endif
            if (m_halted || halt) begin
               n_halted = 1; n_pend = 0; n_pend_pc = 0;
            end else if (m_pend) begin
               if (ihit) begin
                  e_en = 1; e_pc = redir_valid ? ra : m_pend_pc; n_pend = 0;
               end else if (redir_valid) begin
                  n_pend_pc = ra;
               end
            end else if (redir_valid) begin
               if (ihit) begin
                  e_en = 1; e_pc = ra;
               end else begin
                  n_pend = 1; n_pend_pc = ra;
               end
            end else if (ihit && !stall) begin
               e_en = 1;
               e_pred = hit;
               e_pc = hit ? (m_tgt[li] & 32'hFFFF_FFFC) : (npc & 32'hFFFF_FFFC);
            end
`ifdef BRANCH_PRED_EN
            if (br_resolve) begin
               wi = int'((br_pc >> 2) % N);
               wt = br_pc >> (IW + 2);
               if (m_v[wi] && m_tag[wi] == wt) begin
                  if (br_taken) begin
                     n_ctr[wi] = (m_ctr[wi] < 3) ? m_ctr[wi] + 1 : 3;
                     n_tgt[wi] = br_target;
                  end else begin
                     n_ctr[wi] = (m_ctr[wi] > 0) ? m_ctr[wi] - 1 : 0;
                  end
               end else if (br_taken) begin
                  n_v[wi] = 1; n_tag[wi] = wt; n_ctr[wi] = 2; n_tgt[wi] = br_target;
               end
            end
`endif
            chk("en", 32'(en), 32'(e_en));
            chk("pred_taken", 32'(pred_taken), 32'(e_pred));
            chk("halted", 32'(halted), 32'(m_halted));
            if (e_en) chk("new_pc", new_pc, e_pc);
         end
         @(posedge CLK);
         m_halted = n_halted; m_pend = n_pend; m_pend_pc = n_pend_pc;
         m_v = n_v; m_tag = n_tag; m_tgt = n_tgt; m_ctr = n_ctr;
      end
   end

   task automatic set_idle();
      ihit = 0; stall = 0; halt = 0; redir_valid = 0; redir_pc = 0;
      br_resolve = 0; br_pc = 0; br_taken = 0; br_target = 0;
      curr_pc = 0; npc = 4;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      set_idle();
      nRST = 0;
      @(negedge CLK);
      chk("lit_rst_en", 32'(en), 32'd0);
      chk("lit_rst_new_pc", new_pc, 32'd0);
      chk("lit_rst_halted", 32'(halted), 32'd0);

      // First fetch after reset goes sequential.
      next_cycle();
      nRST = 1; ihit = 1; curr_pc = 0; npc = 4;
      @(negedge CLK);
      chk("lit_first_en", 32'(en), 32'd1);
      chk("lit_first_pc", new_pc, 32'h4);
      chk("lit_first_pred", 32'(pred_taken), 32'd0);

      // Redirect while the fetch is outstanding, resolved three cycles later.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         ihit = (i == 0) ? 1'b0 : ihit;
         redir_valid = 1; redir_pc = 32'h103; curr_pc = 32'h4; npc = 32'h8;
         @(negedge CLK);
         chk("lit_pend_en", 32'(en), 32'd0);
      end
      next_cycle();
      redir_valid = 0; ihit = 1;
      @(negedge CLK);
      chk("lit_pend_en1", 32'(en), 32'd1);
      chk("lit_pend_pc", new_pc, 32'h100);
      next_cycle();
      curr_pc = 32'h100; npc = 32'h104;
      @(negedge CLK);
      chk("lit_run_again", new_pc, 32'h104);

      // Redirect outranks stall.
      next_cycle();
      stall = 1; redir_valid = 1; redir_pc = 32'h200; ihit = 1;
      @(negedge CLK);
      chk("lit_stall_redir_en", 32'(en), 32'd1);
      chk("lit_stall_redir_pc", new_pc, 32'h200);
      next_cycle();
      redir_valid = 0;
      @(negedge CLK);
      chk("lit_stall_en", 32'(en), 32'd0);

      // BTB: allocate, predict (with a same-cycle not-taken update), then train away.
      next_cycle();
      stall = 0; ihit = 0; br_resolve = 1; br_pc = 32'h40; br_taken = 1; br_target = 32'h80;
      next_cycle();
      curr_pc = 32'h40; npc = 32'h44; ihit = 1; br_taken = 0; br_target = 0;
      @(negedge CLK);
`ifdef BRANCH_PRED_EN
      chk("lit_btb_pc", new_pc, 32'h80);
      chk("lit_btb_pred", 32'(pred_taken), 32'd1);
`else
      chk("lit_btb_pc", new_pc, 32'h44);
      chk("lit_btb_pred", 32'(pred_taken), 32'd0);
`endif
      next_cycle();
      ihit = 0;
      next_cycle();
      br_resolve = 0; ihit = 1;
      @(negedge CLK);
      chk("lit_btb_trained_pc", new_pc, 32'h44);
      chk("lit_btb_trained_pred", 32'(pred_taken), 32'd0);

      // Halt beats redirect and sticks until reset.
      next_cycle();
      halt = 1; redir_valid = 1; redir_pc = 32'h300;
      @(negedge CLK);
      chk("lit_halt_en", 32'(en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         halt = 0; ihit = 1'($urandom); redir_valid = 1'($urandom); stall = 0;
         @(negedge CLK);
         chk("lit_halted", 32'(halted), 32'd1);
         chk("lit_halted_en", 32'(en), 32'd0);
      end
      next_cycle();
      ihit = 1; redir_valid = 1;
      #2;
      nRST = 0;
      #1;
      chk("lit_async_halted", 32'(halted), 32'd0);
      chk("lit_async_en", 32'(en), 32'd0);
      chk("lit_async_pc", new_pc, 32'd0);
      next_cycle();
      set_idle();
      nRST = 1;

      // Random traffic over a small PC window so BTB entries alias and retrain.
      for (int c = 0; c < 3000; c++) begin
         next_cycle();
         curr_pc     = 32'($urandom_range(0, 31)) * 4;
         npc         = curr_pc + 4;
         ihit        = ($urandom_range(0, 9) < 7);
         stall       = ($urandom_range(0, 4) == 0);
         redir_valid = ($urandom_range(0, 6) == 0);
         redir_pc    = $urandom;
         br_resolve  = ($urandom_range(0, 2) == 0);
         br_pc       = 32'($urandom_range(0, 31)) * 4;
         br_taken    = ($urandom_range(0, 2) != 0);
         br_target   = $urandom;
         halt        = ($urandom_range(0, 149) == 0);
         nRST        = ($urandom_range(0, 59) != 0);
      end
      next_cycle();
      @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
